// File: rtl/pitch_shift_frame.sv
// pitch_shift_frame
// Frame-based pitch shifter. Incoming samples fill one half of a ping-pong
// input buffer while the other half is resampled cyclically, with linear
// interpolation, into a ping-pong output buffer. The output buffers are
// replayed on the same sample strobe, two frames behind the input.
module pitch_shift_frame #(
    parameter int DW         = 16,
    parameter int FRAME_LOG2 = 10,
    parameter int FRAC       = 8,
    parameter int RATIO_W    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic [DW-1:0]      SampleIn,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               bypass,
    output logic [DW-1:0]      SampleOut,
    output logic               frame_done,
    output logic               busy,
    output logic               overrun
);

    localparam int N  = 1 << FRAME_LOG2;
    localparam int PW = FRAC + FRAME_LOG2;   // phase accumulator width
    localparam int MW = DW + FRAC + 2;       // interpolation product width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD0,
        RD1,
        CALC,
        WR
    } stateType;

    // Frame storage: bank bit is the MSB of the address.
    logic [DW-1:0] inBuf  [0:2*N-1];
    logic [DW-1:0] outBuf [0:2*N-1];

    // Sample-side pointers.
    logic [FRAME_LOG2-1:0] wpReg;
    logic                  bankReg;
    logic [1:0]            writtenReg;
    logic                  req;

    // Processing state.
    stateType              stateReg;
    stateType              stateNext;
    logic                  pbReg;
    logic [FRAME_LOG2-1:0] kReg;
    logic [PW-1:0]         phaseReg;
    logic [RATIO_W-1:0]    ratioLat;
    logic                  bypassLat;
    logic [DW-1:0]         rdData;
    logic [DW-1:0]         x0Reg;
    logic [DW-1:0]         yReg;
    logic [DW-1:0]         yNext;
    logic [FRAME_LOG2-1:0] rdIdx;
    logic [FRAME_LOG2-1:0] phaseInt;
    logic [FRAC-1:0]       phaseFrac;
    logic                  frameDoneReg;
    logic                  overrunReg;
    logic                  lastSample;

    // A frame is complete when the last slot of the current bank is written.
    assign req        = ready && (&wpReg);
    assign phaseInt   = phaseReg[PW-1:FRAC];
    assign phaseFrac  = phaseReg[FRAC-1:0];
    assign lastSample = &kReg;

    assign busy       = (stateReg != IDLE);
    assign frame_done = frameDoneReg;
    assign overrun    = overrunReg;

    // Sample side: advance the shared pointer, flip banks at frame end and
    // replay the matching output slot (silence until that bank holds a frame).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wpReg     <= '0;
            bankReg   <= 1'b0;
            SampleOut <= '0;
        end else if (ready) begin
            wpReg <= wpReg + FRAME_LOG2'(1);
            if (&wpReg) begin
                bankReg <= ~bankReg;
            end
            if (writtenReg[bankReg]) begin
                SampleOut <= outBuf[{bankReg, wpReg}];
            end else begin
                SampleOut <= '0;
            end
        end
    end

    // Input capture into the bank currently being filled.
    always_ff @(posedge clk) begin
        if (ready) begin
            inBuf[{bankReg, wpReg}] <= SampleIn;
        end
    end

    // Read address for the processing side: bypass walks k directly,
    // otherwise RD1 fetches the right-hand neighbour, wrapping at N.
    always_comb begin
        rdIdx = phaseInt;
        if (bypassLat) begin
            rdIdx = kReg;
        end else if (stateReg == RD1) begin
            rdIdx = phaseInt + FRAME_LOG2'(1);
        end
    end

    // Registered read port of the input buffer for the frame being processed.
    always_ff @(posedge clk) begin
        rdData <= inBuf[{pbReg, rdIdx}];
    end

    // Resampled output written into the bank of the frame being processed.
    always_ff @(posedge clk) begin
        if (stateReg == WR) begin
            outBuf[{pbReg, kReg}] <= yReg;
        end
    end

    // Linear interpolation: y = x0 + floor((x1 - x0) * f / 2^FRAC).
    // The difference needs one extra bit; the product is multiplied by the
    // non-negative fraction and shifted arithmetically so it rounds to -inf.
    // The result always lies between x0 and x1, so truncation to DW is exact.
    always_comb begin
        logic signed [DW:0]   diff;
        logic signed [MW-1:0] prod;
        logic signed [MW-1:0] x0Ext;
        diff  = $signed({rdData[DW-1], rdData}) - $signed({x0Reg[DW-1], x0Reg});
        prod  = MW'(diff * $signed({1'b0, phaseFrac}));
        x0Ext = MW'($signed(x0Reg));
        yNext = bypassLat ? x0Reg : DW'(x0Ext + (prod >>> FRAC));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // FSM next-state: one LOAD per frame, then four cycles per output sample.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (req) stateNext = LOAD;
            LOAD:    stateNext = RD0;
            RD0:     stateNext = RD1;
            RD1:     stateNext = CALC;
            CALC:    stateNext = WR;
            WR:      stateNext = lastSample ? IDLE : RD0;
            default: stateNext = IDLE;
        endcase
    end

    // Processing datapath, frame bookkeeping and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pbReg        <= 1'b0;
            kReg         <= '0;
            phaseReg     <= '0;
            ratioLat     <= '0;
            bypassLat    <= 1'b0;
            x0Reg        <= '0;
            yReg         <= '0;
            writtenReg   <= 2'b00;
            frameDoneReg <= 1'b0;
            overrunReg   <= 1'b0;
        end else begin
            frameDoneReg <= 1'b0;
            // A completed frame can only be taken while idle; otherwise it is lost.
            if (req && stateReg != IDLE) begin
                overrunReg <= 1'b1;
            end
            case (stateReg)
                IDLE: begin
                    if (req) begin
                        pbReg <= bankReg;
                    end
                end
                LOAD: begin
                    ratioLat  <= ratio;
                    bypassLat <= bypass;
                    phaseReg  <= '0;
                    kReg      <= '0;
                end
                RD1: begin
                    x0Reg <= rdData;
                end
                CALC: begin
                    yReg <= yNext;
                end
                WR: begin
                    phaseReg <= phaseReg + PW'(ratioLat);
                    if (lastSample) begin
                        writtenReg[pbReg] <= 1'b1;
                        frameDoneReg      <= 1'b1;
                    end else begin
                        kReg <= kReg + FRAME_LOG2'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
